// File: rtl/rtf65002_ibuf8.sv
// Instruction byte prefetch queue for the 8-bit-opcode mode: fetches aligned words,
// buffers bytes and presents the next four instruction bytes (opcode in [7:0]).
module rtf65002_ibuf8 #(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] RST_ADR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_adr_i,
  input  logic        adv_i,
  input  logic [2:0]  adv_len_i,
  output logic [31:0] ins_o,
  output logic [2:0]  ins_avail_o,
  output logic [31:0] pc_o,
  output logic        fetch_req_o,
  output logic [31:0] fetch_adr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] fetch_dat_i,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = 8 * DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [QW-1:0]   r_q, w_q_nxt;
  logic [CW-1:0]   r_count, w_count_nxt, w_base;
  logic [31:0]     r_pc, w_pc_nxt;
  logic [31:0]     r_fadr, w_fadr_nxt;
  logic [1:0]      r_skip, w_skip_nxt;
  logic [31:0]     r_ins, w_ins_nxt;
  logic [2:0]      r_avail, w_avail_nxt;
  logic            r_req, r_err, w_err_nxt;
  logic            w_adv_ok, w_ack_take;
  logic [31:0]     w_word;

  // Fetch handshake: fetch_req_o is held with a stable request until fetch_ack_i is
  // seen high at a clock edge; fetch_dat_i is sampled on that same edge. Only one
  // request is ever outstanding, and a started bus cycle is always completed.
  assign w_adv_ok   = adv_i && (adv_len_i != 3'd0) && (adv_len_i <= r_avail);
  assign w_ack_take = (r_state == ST_REQ) && fetch_ack_i && !flush_i;
  assign w_word     = fetch_dat_i >> {r_skip, 3'b000};
  assign w_err_nxt  = adv_i && !flush_i && !w_adv_ok;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!flush_i && (r_count <= CW'(DEPTH - 4))) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (fetch_ack_i)  w_state_nxt = ST_IDLE;
        else if (flush_i) w_state_nxt = ST_DROP;
      end
      ST_DROP: if (fetch_ack_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bytes at or above count are kept zero, so an append can simply OR in the word.
  always_comb begin
    w_q_nxt     = r_q;
    w_count_nxt = r_count;
    w_pc_nxt    = r_pc;
    w_fadr_nxt  = r_fadr;
    w_skip_nxt  = r_skip;
    w_base      = r_count;
    if (flush_i) begin
      w_q_nxt     = '0;
      w_count_nxt = '0;
      w_pc_nxt    = flush_adr_i;
      w_fadr_nxt  = {flush_adr_i[31:2], 2'b00};
      w_skip_nxt  = flush_adr_i[1:0];
    end else begin
      if (w_adv_ok) begin
        w_q_nxt  = r_q >> {adv_len_i, 3'b000};
        w_base   = r_count - CW'(adv_len_i);
        w_pc_nxt = r_pc + 32'(adv_len_i);
      end
      w_count_nxt = w_base;
      if (w_ack_take) begin
        w_q_nxt     = w_q_nxt | (QW'(w_word) << {w_base, 3'b000});
        w_count_nxt = w_base + CW'(3'd4 - {1'b0, r_skip});
        w_fadr_nxt  = r_fadr + 32'd4;
        w_skip_nxt  = 2'd0;
      end
    end
    w_avail_nxt = (w_count_nxt >= CW'(4)) ? 3'd4 : w_count_nxt[2:0];
    w_ins_nxt   = w_q_nxt[31:0] & ~(32'hFFFF_FFFF << {w_avail_nxt, 3'b000});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_count <= '0;
      r_pc    <= RST_ADR;
      r_fadr  <= {RST_ADR[31:2], 2'b00};
      r_skip  <= RST_ADR[1:0];
      r_ins   <= 32'd0;
      r_avail <= 3'd0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_pc    <= w_pc_nxt;
      r_fadr  <= w_fadr_nxt;
      r_skip  <= w_skip_nxt;
      r_ins   <= w_ins_nxt;
      r_avail <= w_avail_nxt;
      r_req   <= (w_state_nxt != ST_IDLE);
      r_err   <= w_err_nxt;
    end
  end

  assign ins_o       = r_ins;
  assign ins_avail_o = r_avail;
  assign pc_o        = r_pc;
  assign fetch_req_o = r_req;
  assign fetch_adr_o = r_fadr;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rtf65002_ibuf8.sv
// Directed bench for rtf65002_ibuf8: a DEPTH=8 and a DEPTH=12 instance, each with a
// memory whose word at address a holds bytes a, a+1, a+2, a+3 (low address byte only).
module tb_rtf65002_ibuf8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=8 instance signals
  logic        flush8, adv8, ack_en8, ack8, req8, err8;
  logic [31:0] flush_adr8, ins8, pc8, fadr8, dat8;
  logic [2:0]  adv_len8, avail8;
  logic [1:0]  st8;

  // DEPTH=12 instance signals
  logic        flush12, adv12, ack_en12, ack12, req12, err12;
  logic [31:0] flush_adr12, ins12, pc12, fadr12, dat12;
  logic [2:0]  adv_len12, avail12;
  logic [1:0]  st12;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  assign ack8  = ack_en8 && req8;
  assign dat8  = mem_word(fadr8);
  assign ack12 = ack_en12 && req12;
  assign dat12 = mem_word(fadr12);

  rtf65002_ibuf8 #(.DEPTH(8), .RST_ADR(32'h0)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush8), .flush_adr_i(flush_adr8),
    .adv_i(adv8), .adv_len_i(adv_len8), .ins_o(ins8), .ins_avail_o(avail8),
    .pc_o(pc8), .fetch_req_o(req8), .fetch_adr_o(fadr8), .fetch_ack_i(ack8),
    .fetch_dat_i(dat8), .err_o(err8), .dbg_state_o(st8)
  );

  rtf65002_ibuf8 #(.DEPTH(12), .RST_ADR(32'h0)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush12), .flush_adr_i(flush_adr12),
    .adv_i(adv12), .adv_len_i(adv_len12), .ins_o(ins12), .ins_avail_o(avail12),
    .pc_o(pc12), .fetch_req_o(req12), .fetch_adr_o(fadr12), .fetch_ack_i(ack12),
    .fetch_dat_i(dat12), .err_o(err12), .dbg_state_o(st12)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush8 = 0; flush_adr8 = 0; adv8 = 0; adv_len8 = 0; ack_en8 = 0;
    flush12 = 0; flush_adr12 = 0; adv12 = 0; adv_len12 = 0; ack_en12 = 0;
    repeat (3) step();

    chk("rst_req", {31'd0, req8}, 32'd0);
    chk("rst_adr", fadr8, 32'h0);
    chk("rst_pc", pc8, 32'h0);
    chk("rst_ins", ins8, 32'h0);
    chk("rst_avail", {29'd0, avail8}, 32'd0);
    chk("rst_err", {31'd0, err8}, 32'd0);
    chk("rst_state", {30'd0, st8}, 32'd0);
    chk("rst_req12", {31'd0, req12}, 32'd0);

    // First word after reset with zero-wait memory
    rst_n = 1'b1; ack_en8 = 1;
    step();
    chk("p1_req", {31'd0, req8}, 32'd1);
    chk("p1_adr", fadr8, 32'h0);
    step();
    chk("w0_ins", ins8, 32'h0302_0100);
    chk("w0_avail", {29'd0, avail8}, 32'd4);
    chk("w0_pc", pc8, 32'h0);
    adv8 = 1; adv_len8 = 3'd2;
    step();
    adv8 = 0;
    chk("adv2_pc", pc8, 32'h2);
    chk("adv2_ins", {16'd0, ins8[15:0]}, 32'h0302);
    chk("adv2_avail", {29'd0, avail8}, 32'd2);
    step();
    chk("w1_ins", ins8, 32'h0504_0302);
    chk("w1_avail", {29'd0, avail8}, 32'd4);

    // Flush to an unaligned address: only byte 3 of the first word survives
    flush8 = 1; flush_adr8 = 32'h0000_1003;
    step();
    flush8 = 0;
    chk("fl_pc", pc8, 32'h1003);
    chk("fl_adr", fadr8, 32'h1000);
    chk("fl_avail", {29'd0, avail8}, 32'd0);
    chk("fl_req0", {31'd0, req8}, 32'd0);
    step();
    chk("fl_req1", {31'd0, req8}, 32'd1);
    chk("fl_req_adr", fadr8, 32'h1000);
    step();
    chk("fl_avail1", {29'd0, avail8}, 32'd1);
    chk("fl_ins1", ins8, 32'h0000_0003);
    chk("fl_pc1", pc8, 32'h1003);
    step();
    step();
    chk("fl_avail4", {29'd0, avail8}, 32'd4);
    chk("fl_ins4", ins8, 32'h0605_0403);

    // Flush while a request waits: DROP holds the request and discards its data
    ack_en8 = 0; adv8 = 1; adv_len8 = 3'd2;
    step();
    adv8 = 0;
    chk("d_ins", ins8, 32'h0007_0605);
    chk("d_pc", pc8, 32'h1005);
    step();
    chk("d_req", {31'd0, req8}, 32'd1);
    chk("d_st_req", {30'd0, st8}, 32'd1);
    chk("d_adr", fadr8, 32'h1008);
    step();
    flush8 = 1; flush_adr8 = 32'h0000_2002;
    step();
    flush8 = 0;
    chk("d_st_drop", {30'd0, st8}, 32'd2);
    chk("d_req_held", {31'd0, req8}, 32'd1);
    chk("d_pc_fl", pc8, 32'h2002);
    step();
    chk("d_st_drop2", {30'd0, st8}, 32'd2);
    ack_en8 = 1;
    step();
    chk("d_st_idle", {30'd0, st8}, 32'd0);
    chk("d_req_low", {31'd0, req8}, 32'd0);
    chk("d_discard", {29'd0, avail8}, 32'd0);
    step();
    chk("d_new_adr", fadr8, 32'h2000);
    chk("d_new_req", {31'd0, req8}, 32'd1);
    step();
    chk("d_new_avail", {29'd0, avail8}, 32'd2);
    chk("d_new_ins", ins8, 32'h0000_0302);
    chk("d_new_pc", pc8, 32'h2002);

    // Flush overrides an illegal advance; then fill to full with no advance
    flush8 = 1; flush_adr8 = 32'h0000_3000; adv8 = 1; adv_len8 = 3'd0;
    step();
    flush8 = 0; adv8 = 0;
    chk("fo_err", {31'd0, err8}, 32'd0);
    chk("fo_pc", pc8, 32'h3000);
    repeat (6) step();
    chk("full_req", {31'd0, req8}, 32'd0);
    chk("full_avail", {29'd0, avail8}, 32'd4);
    chk("full_ins", ins8, 32'h0302_0100);
    chk("full_adr", fadr8, 32'h3008);
    adv8 = 1; adv_len8 = 3'd1;
    step();
    adv8 = 0;
    chk("c7_pc", pc8, 32'h3001);
    chk("c7_ins", ins8, 32'h0403_0201);
    chk("c7_req", {31'd0, req8}, 32'd0);
    step();
    chk("c7_req2", {31'd0, req8}, 32'd0);
    adv8 = 1; adv_len8 = 3'd3;
    step();
    adv8 = 0;
    chk("c4_pc", pc8, 32'h3004);
    chk("c4_ins", ins8, 32'h0706_0504);
    chk("c4_req", {31'd0, req8}, 32'd0);
    step();
    chk("c4_req2", {31'd0, req8}, 32'd1);
    chk("c4_adr", fadr8, 32'h3008);

    // DEPTH=12: advance 4 coincident with an ack from count 6
    ack_en12 = 1;
    step();
    chk("e_ins0", ins12, 32'h0302_0100);
    step();
    step();
    ack_en12 = 0; adv12 = 1; adv_len12 = 3'd2;
    step();
    chk("e_ins6", ins12, 32'h0504_0302);
    chk("e_st", {30'd0, st12}, 32'd1);
    adv_len12 = 3'd4; ack_en12 = 1;
    step();
    ack_en12 = 0;
    chk("e_coinc_ins", ins12, 32'h0908_0706);
    chk("e_coinc_avail", {29'd0, avail12}, 32'd4);
    chk("e_coinc_pc", pc12, 32'h6);
    step();
    chk("e_cnt_ins", ins12, 32'h0000_0B0A);
    chk("e_cnt_avail", {29'd0, avail12}, 32'd2);
    chk("e_cnt_pc", pc12, 32'hA);
    adv_len12 = 3'd3;
    step();
    adv12 = 0;
    chk("e_err", {31'd0, err12}, 32'd1);
    chk("e_err_avail", {29'd0, avail12}, 32'd2);
    chk("e_err_pc", pc12, 32'hA);
    chk("e_err_ins", ins12, 32'h0000_0B0A);
    step();
    chk("e_err_pulse", {31'd0, err12}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
